// File: rtl/atm_controller.sv
// atm_controller: ATM session sequencer with timeout abort and registered strobes.
// Define ATM_FACE_AUTH_EN to insert the FACE capture stage between AMOUNT and OTP.
module atm_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TXN_DEPOSIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cardInserted,
  input  logic       cardScanned,
  input  logic       modeSelected,
  input  logic       amountConfirmed,
  input  logic       faceRecognition,
  input  logic       mobileOTP,
  input  logic       transactionCompleted,
  output logic       dispenseCash,
  output logic       depositCash,
  output logic       printReceipt,
  output logic       captureFace,
  output logic       promptOTP,
  output logic [7:0] displayMessage
);
`ifdef ATM_FACE_AUTH_EN
  localparam bit FACE_EN = 1'b1;
`else
  localparam bit FACE_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  // Encodings of IDLE..DONE equal their display codes
  typedef enum logic [3:0] {
    S_IDLE, S_CARD, S_SCANNED, S_AMOUNT, S_FACE, S_OTP, S_TXN, S_DONE, S_ERROR
  } state_t;
  state_t state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic adv, waiting, tmo;
  always_comb begin
    adv = 1'b0;
    nxt = state_q;
    case (state_q)
      S_CARD:    begin adv = cardScanned;               nxt = S_SCANNED; end
      S_SCANNED: begin adv = modeSelected;              nxt = S_AMOUNT; end
      S_AMOUNT:  begin adv = amountConfirmed;           nxt = FACE_EN ? S_FACE : S_OTP; end
      S_FACE:    begin adv = FACE_EN && faceRecognition; nxt = S_OTP; end
      S_OTP:     begin adv = mobileOTP;                 nxt = S_TXN; end
      S_TXN:     begin adv = transactionCompleted;      nxt = S_DONE; end
      default:   ;
    endcase
    waiting = state_q inside {S_CARD, S_SCANNED, S_AMOUNT, S_FACE, S_OTP, S_TXN};
    tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = (state_q == S_IDLE) ? (cardInserted ? S_CARD : S_IDLE) :
              !cardInserted ? S_IDLE :
              !waiting ? state_q :
              tmo ? S_ERROR :
              adv ? nxt : state_q;
    cnt_d = (waiting && state_d == state_q) ? cnt_q + CW'(1) : '0;
  end
  // Outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dispenseCash   <= 1'b0;
      depositCash    <= 1'b0;
      printReceipt   <= 1'b0;
      captureFace    <= 1'b0;
      promptOTP      <= 1'b0;
      displayMessage <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dispenseCash   <= state_d == S_TXN && TXN_DEPOSIT == 0;
      depositCash    <= state_d == S_TXN && TXN_DEPOSIT != 0;
      printReceipt   <= state_d == S_DONE;
      captureFace    <= FACE_EN && state_d == S_FACE;
      promptOTP      <= state_d == S_OTP;
      displayMessage <= (state_d == S_ERROR) ? 8'hEE : 8'(state_d);
    end
  end
endmodule

// File: tb/tb_atm_controller.sv
// tb_atm_controller: randomized scoreboard bench for withdrawal and deposit variants.
module tb_atm_controller;
  localparam int T = 16;
`ifdef ATM_FACE_AUTH_EN
  localparam bit FACE = 1'b1;
`else
  localparam bit FACE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, cardInserted, cardScanned, modeSelected, amountConfirmed;
  logic faceRecognition, mobileOTP, transactionCompleted;
  logic w_disp, w_dep, w_rcpt, w_face, w_otp;
  logic d_disp, d_dep, d_rcpt, d_face, d_otp;
  logic [7:0] w_msg, d_msg;
  int checks = 0, failures = 0;
  int exp_q[$];
  int code_m = 0, dwell_m = 0;
  bit hit_done = 0, hit_err = 0, hit_txn = 0;
  always #5 clk = ~clk;
  atm_controller #(.TIMEOUT_CYCLES(T), .TXN_DEPOSIT(0)) dut_w (
    .clk(clk), .reset(reset), .cardInserted(cardInserted), .cardScanned(cardScanned),
    .modeSelected(modeSelected), .amountConfirmed(amountConfirmed),
    .faceRecognition(faceRecognition), .mobileOTP(mobileOTP),
    .transactionCompleted(transactionCompleted), .dispenseCash(w_disp),
    .depositCash(w_dep), .printReceipt(w_rcpt), .captureFace(w_face),
    .promptOTP(w_otp), .displayMessage(w_msg));
  atm_controller #(.TIMEOUT_CYCLES(T), .TXN_DEPOSIT(1)) dut_d (
    .clk(clk), .reset(reset), .cardInserted(cardInserted), .cardScanned(cardScanned),
    .modeSelected(modeSelected), .amountConfirmed(amountConfirmed),
    .faceRecognition(faceRecognition), .mobileOTP(mobileOTP),
    .transactionCompleted(transactionCompleted), .dispenseCash(d_disp),
    .depositCash(d_dep), .printReceipt(d_rcpt), .captureFace(d_face),
    .promptOTP(d_otp), .displayMessage(d_msg));
  function automatic bit cond(int c);
    return c == 1 ? cardScanned : c == 2 ? modeSelected : c == 3 ? amountConfirmed :
           c == 4 ? faceRecognition : c == 5 ? mobileOTP : transactionCompleted;
  endfunction
  // Reference: session position as a display code plus cycles dwelt in it
  always @(posedge clk) begin
    int prev;
    prev = code_m;
    if (reset) code_m = 0;
    else if (code_m == 0) code_m = cardInserted ? 1 : 0;
    else if (code_m == 7 || code_m == 'hEE) code_m = cardInserted ? code_m : 0;
    else if (!cardInserted) code_m = 0;
    else if (dwell_m == T - 1) code_m = 'hEE;
    else if (cond(code_m)) code_m = (code_m == 3 && !FACE) ? 5 : code_m + 1;
    dwell_m = (!reset && code_m == prev && code_m >= 1 && code_m <= 6) ? dwell_m + 1 : 0;
    exp_q.push_back(code_m);
  end
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      hit_done |= e == 7;
      hit_err |= e == 'hEE;
      hit_txn |= e == 6;
      chk("w_msg", int'(w_msg), e);
      chk("w_dispense", int'(w_disp), int'(e == 6));
      chk("w_deposit", int'(w_dep), 0);
      chk("w_receipt", int'(w_rcpt), int'(e == 7));
      chk("w_face", int'(w_face), int'(e == 4));
      chk("w_otp", int'(w_otp), int'(e == 5));
      chk("d_msg", int'(d_msg), e);
      chk("d_dispense", int'(d_disp), 0);
      chk("d_deposit", int'(d_dep), int'(e == 6));
      chk("d_receipt", int'(d_rcpt), int'(e == 7));
      chk("d_face", int'(d_face), int'(e == 4));
      chk("d_otp", int'(d_otp), int'(e == 5));
    end
  end
  task automatic drive(bit r, bit card, bit [5:0] c, int n);
    repeat (n) begin
      @(negedge clk);
      reset = r;
      cardInserted = card;
      {cardScanned, modeSelected, amountConfirmed, faceRecognition, mobileOTP,
       transactionCompleted} = c;
    end
  endtask
  initial begin
    reset = 1'b1;
    cardInserted = 1'b0;
    {cardScanned, modeSelected, amountConfirmed, faceRecognition, mobileOTP,
     transactionCompleted} = '0;
    drive(1, 0, 6'h00, 2);
    drive(0, 1, 6'h3F, 10);
    drive(0, 0, 6'h3F, 2);
    drive(0, 1, 6'h2F, 25);
    drive(0, 0, 6'h00, 2);
    drive(0, 1, 6'h3E, 6);
    drive(1, 1, 6'h3E, 1);
    drive(0, 0, 6'h00, 2);
    for (int s = 0; s < 200; s++) begin
      int mode, len;
      bit [5:0] stall;
      mode = $urandom_range(0, 3);
      len = $urandom_range(5, 40);
      stall = 6'h20 >> $urandom_range(0, 5);
      for (int k = 0; k < len; k++) begin
        bit r, card;
        bit [5:0] c;
        r = $urandom_range(0, 99) == 0;
        card = mode == 2 || $urandom_range(0, 29) != 0;
        c = mode == 0 ? 6'($urandom) : mode == 1 ? 6'h3F : mode == 2 ? ~stall :
            6'($urandom) & 6'($urandom) & 6'($urandom);
        drive(r, card, c, 1);
      end
    end
    drive(0, 0, 6'h00, 3);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 1);
    chk("reached_done", int'(hit_done), 1);
    chk("reached_error", int'(hit_err), 1);
    chk("reached_txn", int'(hit_txn), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/atm_controller.md
# atm_controller

Moore-style transaction sequencer for an ATM front end. It steps a session through card insertion, card scan, mode selection, amount confirmation, optional face capture, mobile OTP, transaction execution and receipt printing. It drives the actuator strobes (cash dispense/deposit, receipt, camera, OTP prompt) and an 8-bit status code for the display subsystem. It sits between the panel/sensor input logic and the actuator and display drivers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: maximum number of cycles spent in any waiting state before the session aborts to ERROR. Legal range is ≥2.
- `TXN_DEPOSIT`, default 0: selects the transaction type. 0 = withdrawal, driving `dispenseCash`. 1 = deposit, driving `depositCash`.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `cardInserted` in 1: level signal; high while a card is in the slot.
- `cardScanned` in 1: level signal; card read is complete.
- `modeSelected` in 1: level signal; user has chosen the transaction mode.
- `amountConfirmed` in 1: level signal; user has confirmed the amount.
- `faceRecognition` in 1: level signal; face match succeeded.
- `mobileOTP` in 1: level signal; OTP verified.
- `transactionCompleted` in 1: level signal; the cash mechanism has finished.
- `dispenseCash` out 1: high in state TXN when `TXN_DEPOSIT`=0.
- `depositCash` out 1: high in state TXN when `TXN_DEPOSIT`=1.
- `printReceipt` out 1: high in state DONE.
- `captureFace` out 1: high in state FACE.
- `promptOTP` out 1: high in state OTP.
- `displayMessage` out 8: status code of the current state.

## Operation
States, with their display codes:
- IDLE 0x00
- CARD 0x01
- SCANNED 0x02
- AMOUNT 0x03
- FACE 0x04
- OTP 0x05
- TXN 0x06
- DONE 0x07
- ERROR 0xEE

Forward transitions, each taken when its condition is high at a clock edge:
- IDLE→CARD on `cardInserted`.
- CARD→SCANNED on `cardScanned`.
- SCANNED→AMOUNT on `modeSelected`.
- AMOUNT→FACE on `amountConfirmed`.
- FACE→OTP on `faceRecognition`.
- OTP→TXN on `mobileOTP`.
- TXN→DONE on `transactionCompleted`.

Exit from the end states:
- DONE stays until `cardInserted`=0, then goes to IDLE.
- ERROR stays until `cardInserted`=0, then goes to IDLE.

Priority rules in the waiting states CARD, SCANNED, AMOUNT, FACE, OTP and TXN, highest first:
1. Card removed (`cardInserted`=0): go to IDLE. This is a silent abort; no actuator asserts.
2. Timeout: go to ERROR.
3. Advance condition: go to the next state.

Input handling:
- Inputs are levels, not pulses; stale highs are not cleared.
- If every input is already high, the FSM advances exactly one state per cycle.
- The FSM never skips a state within one cycle.
- Only the condition belonging to the current state is examined.

Timeout counter:
- Width is clog2(`TIMEOUT_CYCLES`).
- It clears on every state change and in IDLE, DONE and ERROR.
- Otherwise it increments each cycle.
- When it equals `TIMEOUT_CYCLES`-1 and no higher-priority exit applies, the next state is ERROR.

Outputs:
- All outputs are pure decodes of the state register; there is no input-to-output combinational path.
- At most one of the five strobes is high at any time.
- In IDLE, SCANNED, AMOUNT, CARD and ERROR all strobes are 0.

## Timing
- Reset value: state IDLE, counter 0, every strobe 0, `displayMessage`=0x00.
- Reset takes priority over all transitions, including mid-transaction; a TXN state is abandoned without completion.
- Latency is one cycle: an input sampled high at edge N changes the outputs immediately after edge N.
- A full session with all inputs pre-asserted reaches DONE 7 cycles after reset release with the feature enabled, or 6 cycles with it disabled.
- The minimum dwell in DONE is 1 cycle.

## Configuration
`ATM_FACE_AUTH_EN`:
- Defined: the FACE state exists and the sequence is AMOUNT→FACE→OTP.
- Undefined:
  - FACE is removed and AMOUNT→OTP is taken on `amountConfirmed`.
  - `captureFace` is tied to 0.
  - `faceRecognition` is ignored.
  - Code 0x04 is never displayed.

## Test plan
- Nominal withdrawal (macro defined, `TXN_DEPOSIT`=0):
  - Release reset at 10 ns (10 ns clock). Raise, and hold, each input in order at 30, 60, 100, 150, 210, 280 and 360 ns.
  - At 450 ns: `displayMessage`=0x07, `printReceipt`=1, all other strobes 0.
  - Earlier, `captureFace`, `promptOTP` and `dispenseCash` each pulse high only in their own state.
- Deposit (`TXN_DEPOSIT`=1), same stimulus: `depositCash`=1 while code 0x06, `dispenseCash` never 1.
- Card removal in OTP: FSM returns to IDLE (0x00) next cycle; `dispenseCash` never asserts.
- Timeout (`TIMEOUT_CYCLES`=16):
  - Stall in SCANNED with `modeSelected`=0: 0xEE appears exactly 16 cycles after entering SCANNED.
  - Then drop `cardInserted`: 0x00 next cycle.
- Reset asserted for one cycle while in TXN: next cycle all outputs 0 and `displayMessage`=0x00.
- Macro undefined, all inputs pre-asserted: code sequence 0x00, 0x01, 0x02, 0x03, 0x05, 0x06, 0x07 on consecutive cycles; `captureFace` constantly 0.
